// File: rtl/bbpd_voter.sv
// -----------------------------------------------------------------------------
// bbpd_voter
//   Bang-bang (Alexander) phase detector followed by a majority-vote decimator.
//   Each qualified data/edge sample pair casts a vote: +1 when the clock is late
//   and -1 when it is early. A vote is cast only on a data transition that
//   follows an earlier valid sample. Votes are summed over WIN valid samples.
//   When a window closes, a single-cycle up or dn pulse is issued if the
//   magnitude of the sum reaches THRESH.
//
// Parameters
//   WIN    : valid samples per vote window (>=1)
//   THRESH : minimum |window sum| that produces a pulse (>=1)
//   SUM_W  : signed accumulator width, WIN <= 2^(SUM_W-1)-1
//
// Ports
//   clk      in   clock
//   rst      in   asynchronous reset, active-low, released synchronously
//   clr      in   synchronous clear of window state (priority over in_valid)
//   in_valid in   data / edge_smp are qualified this cycle
//   data     in   data sample d[k]
//   edge_smp in   edge sample between d[k-1] and d[k]
//   up       out  one-cycle pulse: clock late, advance phase
//   dn       out  one-cycle pulse: clock early, retard phase
//   win_done out  one-cycle pulse at every window close
//   vote_sum out  registered running signed window sum (debug)
// -----------------------------------------------------------------------------
module bbpd_voter #(
    parameter int WIN    = 16,
    parameter int THRESH = 1,
    parameter int SUM_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    input  logic             data,
    input  logic             edge_smp,
    output logic             up,
    output logic             dn,
    output logic             win_done,
    output logic [SUM_W-1:0] vote_sum
);

    localparam int                      CNT_W  = (WIN > 1) ? $clog2(WIN) : 1;
    localparam logic [CNT_W-1:0]        LAST   = CNT_W'(WIN - 1);
    localparam logic signed [SUM_W-1:0] POS_TH = SUM_W'(THRESH);
    localparam logic signed [SUM_W-1:0] NEG_TH = SUM_W'(-THRESH);

    // Reset synchronizer: the flops below see rst assert asynchronously and
    // release two clock edges after rst rises, aligned to clk.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    logic                    r_d_prev;
    logic                    r_has_prev;
    logic [CNT_W-1:0]        r_count;
    logic signed [SUM_W-1:0] r_acc;
    logic                    r_up;
    logic                    r_dn;
    logic                    r_win_done;

    logic signed [SUM_W-1:0] w_vote;
    logic signed [SUM_W-1:0] w_final;

    // A transition seen by the edge sample on the new side means the edge
    // sample landed after the crossing, so the clock is late (+1). If it
    // matches the old side, the clock is early (-1).
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_vote = '0;
        if (r_has_prev && (data != r_d_prev)) begin
            w_vote = (edge_smp == data) ? SUM_W'(1) : '1;
        end
        w_final = r_acc + w_vote;
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_d_prev   <= 1'b0;
            r_has_prev <= 1'b0;
            r_count    <= '0;
            r_acc      <= '0;
            r_up       <= 1'b0;
            r_dn       <= 1'b0;
            r_win_done <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            // The pulse outputs default low and are raised only on a window close.
            r_up       <= 1'b0;
            r_dn       <= 1'b0;
            r_win_done <= 1'b0;
            if (clr) begin
                r_acc      <= '0;
                r_count    <= '0;
                r_has_prev <= 1'b0;
            end else if (in_valid) begin
                r_d_prev   <= data;
                r_has_prev <= 1'b1;
                if (r_count == LAST) begin
                    r_up       <= (w_final >= POS_TH);
                    r_dn       <= (w_final <= NEG_TH);
                    r_win_done <= 1'b1;
                    r_acc      <= '0;
                    r_count    <= '0;
                end else begin
                    r_acc   <= w_final;
                    r_count <= r_count + 1'b1;
                end
            end
        end
    end

    assign up       = r_up;
    assign dn       = r_dn;
    assign win_done = r_win_done;
    assign vote_sum = r_acc;

    // THRESH above WIN is legal but can never produce a pulse.
    thresh_reachable_a : assert property (@(posedge clk) disable iff (!w_rst_n) THRESH <= WIN)
        else $warning("bbpd_voter: THRESH exceeds WIN, up/dn can never assert");

    up_dn_exclusive_a : assert property (@(posedge clk) disable iff (!w_rst_n) !(r_up && r_dn));

endmodule

// File: tb/tb_bbpd_voter.sv
// -----------------------------------------------------------------------------
// tb_bbpd_voter
//   Directed bench for bbpd_voter. Two instances share the stimulus: dut uses
//   THRESH=1 and dut2 uses THRESH=2. Vectors are {inputs, expected outputs}
//   records with hand-derived expectations. Each vector is applied on one
//   clock and the registered outputs are compared on the following falling edge.
// -----------------------------------------------------------------------------
module tb_bbpd_voter;

    logic       clk;
    logic       rst;
    logic       clr;
    logic       in_valid;
    logic       data;
    logic       edge_smp;
    logic       up;
    logic       dn;
    logic       win_done;
    logic [7:0] vote_sum;
    logic       up2;
    logic       dn2;
    logic       win_done2;
    logic [7:0] vote_sum2;

    int checks   = 0;
    int failures = 0;

    bbpd_voter #(.WIN(16), .THRESH(1), .SUM_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .in_valid (in_valid),
        .data     (data),
        .edge_smp (edge_smp),
        .up       (up),
        .dn       (dn),
        .win_done (win_done),
        .vote_sum (vote_sum)
    );

    bbpd_voter #(.WIN(16), .THRESH(2), .SUM_W(8)) dut2 (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .in_valid (in_valid),
        .data     (data),
        .edge_smp (edge_smp),
        .up       (up2),
        .dn       (dn2),
        .win_done (win_done2),
        .vote_sum (vote_sum2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit iv;
        bit d;
        bit e;
        bit c;
        bit up;
        bit dn;
        bit done;
        bit up2;
        int sum;
    } vec_t;

    vec_t vecs[$];

    function automatic void push(bit iv, bit d, bit e, bit c,
                                 bit xup, bit xdn, bit xdone, bit xup2, int xsum);
        vec_t v;
        v.iv   = iv;
        v.d    = d;
        v.e    = e;
        v.c    = c;
        v.up   = xup;
        v.dn   = xdn;
        v.done = xdone;
        v.up2  = xup2;
        v.sum  = xsum;
        vecs.push_back(v);
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Apply one set of inputs across a rising edge and return at the falling edge.
    task automatic drive(bit iv, bit d, bit e, bit c);
        in_valid = iv;
        data     = d;
        edge_smp = e;
        clr      = c;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0;
        data     = 1'b0;
        edge_smp = 1'b0;
        clr      = 1'b0;
    endtask

    initial begin
        bit d;

        // T1: alternating data, edge == data -> late; sum after sample k is k.
        for (int k = 0; k < 16; k++) begin
            d = bit'(k & 1);
            push(1, d, d, 0, k == 15, 0, k == 15, k == 15, (k == 15) ? 0 : k);
        end
        push(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // T2: edge == previous data -> early; sum after sample k is -k.
        push(0, 0, 0, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 16; k++) begin
            d = bit'(k & 1);
            push(1, d, ~d, 0, 0, k == 15, k == 15, 0, (k == 15) ? 0 : -k);
        end
        push(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // T3: constant data over three windows -> no votes, three win_done pulses.
        push(0, 0, 0, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 48; k++) begin
            push(1, 1, bit'(k & 1), 0, 0, 0, (k % 16) == 15, 0, 0);
        end
        push(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // T4: transitions 1..8 late, 9..15 early -> final +1: up for THRESH=1 only.
        push(0, 0, 0, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 16; k++) begin
            d = bit'(k & 1);
            push(1, d, (k <= 8) ? d : ~d, 0, k == 15, 0, k == 15, 0,
                 (k == 15) ? 0 : ((k <= 8) ? k : 16 - k));
        end
        push(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // T5: T1 with a gap after every valid sample. Gap data is inverted to
        // show an unqualified sample changes nothing.
        push(0, 0, 0, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 16; k++) begin
            d = bit'(k & 1);
            push(1, d, d, 0, k == 15, 0, k == 15, k == 15, (k == 15) ? 0 : k);
            push(0, ~d, ~d, 0, 0, 0, 0, 0, (k == 15) ? 0 : k);
        end

        // T6: clr at sample 10 of a late window; then a fresh window whose first
        // sample differs from the pre-clr data but must still vote 0.
        push(0, 0, 0, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 10; k++) begin
            d = bit'(k & 1);
            push(1, d, d, 0, 0, 0, 0, 0, k);
        end
        push(1, 0, 0, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 16; k++) begin
            d = bit'(k & 1);
            push(1, d, d, 0, k == 15, 0, k == 15, k == 15, (k == 15) ? 0 : k);
        end
        push(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset state
        rst = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        check("reset up", int'(up), 0);
        check("reset dn", int'(dn), 0);
        check("reset win_done", int'(win_done), 0);
        check("reset vote_sum", int'($signed(vote_sum)), 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Table-driven part
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].iv, vecs[i].d, vecs[i].e, vecs[i].c);
            check($sformatf("v%0d up", i), int'(up), int'(vecs[i].up));
            check($sformatf("v%0d dn", i), int'(dn), int'(vecs[i].dn));
            check($sformatf("v%0d win_done", i), int'(win_done), int'(vecs[i].done));
            check($sformatf("v%0d vote_sum", i), int'($signed(vote_sum)), vecs[i].sum);
            check($sformatf("v%0d up_th2", i), int'(up2), int'(vecs[i].up2));
            check($sformatf("v%0d dn_th2", i), int'(dn2), int'(vecs[i].dn));
            check($sformatf("v%0d win_done_th2", i), int'(win_done2), int'(vecs[i].done));
            check($sformatf("v%0d vote_sum_th2", i), int'($signed(vote_sum2)), vecs[i].sum);
        end

        // Reset mid-window: vote_sum must clear without a clock edge.
        drive(0, 0, 0, 1);
        for (int k = 0; k < 5; k++) begin
            drive(1, bit'(k & 1), bit'(k & 1), 0);
        end
        check("pre-reset vote_sum", int'($signed(vote_sum)), 4);
        rst = 1'b0;
        #1;
        check("async reset vote_sum", int'($signed(vote_sum)), 0);
        check("async reset up", int'(up), 0);
        check("async reset dn", int'(dn), 0);
        #1;
        rst = 1'b1;
        idle_inputs();
        repeat (3) @(negedge clk);

        // Fresh late window after reset, then reset while the up pulse is high.
        for (int k = 0; k < 16; k++) begin
            drive(1, bit'(k & 1), bit'(k & 1), 0);
        end
        check("post-reset window up", int'(up), 1);
        check("post-reset window win_done", int'(win_done), 1);
        rst = 1'b0;
        #1;
        check("async reset drops up", int'(up), 0);
        check("async reset drops win_done", int'(win_done), 0);
        #1;
        rst = 1'b1;
        idle_inputs();
        repeat (3) @(negedge clk);
        check("final idle up", int'(up), 0);
        check("final idle vote_sum", int'($signed(vote_sum)), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bbpd_voter.md
Name: bbpd_voter

Overview:
- Bang-bang (Alexander) phase detector with a majority-vote decimator.
- Consumes per-UI data and edge samples from the receiver slicers.
- Produces single-cycle up/dn pulses that drive the digital loop filter's up/dn inputs, at a rate reduced by the vote window.
- Sits between the sampler front-end and the loop filter in the CDR path.

Parameters:
WIN, 16, number of valid samples per vote window (>=1)
THRESH, 1, minimum |window vote sum| required to emit a pulse (>=1)
SUM_W, 8, signed accumulator width; requires WIN <= 2^(SUM_W-1)-1

Ports:
clk  input  1  triggering clock
rst  input  1  asynchronous reset, active-low (0 = reset)
clr  input  1  synchronous clear of window state
in_valid  input  1  data/edge_smp qualify this cycle
data  input  1  data sample d[k]
edge_smp  input  1  edge sample between d[k-1] and d[k]
up  output  1  one-cycle pulse: clock late, advance phase
dn  output  1  one-cycle pulse: clock early, retard phase
win_done  output  1  one-cycle pulse at every window close
vote_sum  output  SUM_W  registered running signed window sum (debug)

Behaviour:
- Reset (rst=0, asynchronous assert, synchronous release): up=dn=win_done=0, vote_sum=0, count=0, d_prev=0, has_prev=0.
- Per-sample vote v (combinational, evaluated only when in_valid=1):
  - has_prev=0, or data==d_prev: v=0.
  - data!=d_prev and edge_smp==data: v=+1 (late).
  - data!=d_prev and edge_smp==d_prev: v=-1 (early).
- On every in_valid=1 (and clr=0): d_prev<=data, has_prev<=1.
- Window, with count in 0..WIN-1:
  - count<WIN-1: acc<=acc+v, count<=count+1.
  - count==WIN-1: final=acc+v. up<=(final>=THRESH), dn<=(final<=-THRESH), win_done<=1, acc<=0, count<=0.
- vote_sum mirrors acc; it reads 0 in the cycle after a window close.
- Arithmetic is signed SUM_W. No saturation is needed given the parameter constraint.
- Latency: up/dn/win_done assert in the clock cycle following the clk edge that accepted the closing sample. They deassert the next cycle unconditionally.
- up and dn are never both 1.
- in_valid=0: all state holds, v is ignored, and up/dn/win_done are 0 that cycle. Gaps of any length are allowed within a window.
- clr=1 (priority over in_valid): acc=0, count=0, has_prev=0, and no pulse that cycle. The in-flight window is discarded, and the first valid sample after clr produces no vote.
- Reset mid-window: the window is discarded immediately, and outputs drop asynchronously.
- WIN=1: each valid sample closes a window. A pulse appears iff |v|>=THRESH, i.e. per-transition operation when THRESH=1.
- THRESH greater than WIN: pulses never occur. This is legal but flagged by a simulation assertion.

Test Plan:
1. Reset then 16 valid samples, data alternating 0,1,0,..., edge_smp==data -> first sample votes 0, final=+15; after the 16th accepted sample up=1 for exactly one cycle, dn=0, win_done=1, then vote_sum=0.
2. Same data with edge_smp==d_prev -> final=-15, dn one-cycle pulse, up=0.
3. Constant data=1 for 16 samples -> final=0, win_done pulses, up=dn=0; repeated for 3 windows gives 3 win_done pulses and no up/dn.
4. Window with 8 late and 7 early transitions (final=+1): THRESH=1 -> up pulse; rerun with THRESH=2 -> no pulse, win_done only.
5. Stimulus of test 1 with in_valid low on alternate cycles -> identical up pulse, asserted one cycle after the 16th valid sample; vote_sum steps match test 1 at each accepted sample.
6. clr at sample 10 of a late window, then 16 fresh late samples -> no pulse at the aborted window, final=+15 up pulse at the end of the new window. Also assert rst=0 at sample 5 -> up/dn/vote_sum go to 0 without waiting for a clk edge.
